rip_add_seq: RTL and testbench

Multi-cycle sequencer that adds two WIDTH-bit operands by time-sharing one 4-bit ripple-carry adder (`rip_add`), one nibble per cycle, LSB nibble first, with the carry chained between cycles in a register. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It trades latency for area wherever a full-width adder is not justified.

---
 rtl/rip_add_seq_pkg.sv | 22 ++
 rtl/rip_add.sv | 31 +++
 rtl/rip_add_seq.sv | 149 ++++++++++++++
 tb/tb_rip_add_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rip_add_seq_pkg.sv
// rip_add_seq_pkg
// Shared definitions for the nibble-serial adder sequencer: nibble width,
// FSM state type and a helper that sizes the nibble index register.
// No ports (package).

package rip_add_seq_pkg;

  // Width of one slice handled by the shared ripple adder each cycle.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rip_add_seq_state_t;

  // Bits needed to count nibbles 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rip_add.sv
// rip_add
// Purely combinational 4-bit ripple-carry adder: {Cout,Sum} = A + B + Cin.
// Ports:
//   A, B  in  4  addends
//   Cin   in  1  carry in to bit 0
//   Sum   out 4  sum bits
//   Cout  out 1  carry out of bit 3

module rip_add (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  // One full adder per bit, carry rippling from bit 0 upwards.
  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    Cout = c[4];
  end

endmodule

// File: rtl/rip_add_seq.sv
// rip_add_seq
// Adds two WIDTH-bit operands by reusing one 4-bit ripple adder, one nibble
// per cycle (LSB nibble first), chaining the carry through a register.
// Operands arrive on a valid/ready handshake and the result leaves on another.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature: define RIP_ADD_SEQ_OVF_EN to add the signed overflow
// output 'ovf'.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operands presented
//   in_ready   out 1      high in IDLE only
//   a, b       in  WIDTH  addends, sampled at the accept edge only
//   cin        in  1      carry into nibble 0
//   out_valid  out 1      result held in DONE
//   out_ready  in  1      consumer takes the result
//   sum        out WIDTH  registered result
//   cout       out 1      carry out of the top nibble
//   busy       out 1      high while nibbles are being added
//   ovf        out 1      signed overflow (RIP_ADD_SEQ_OVF_EN only)

module rip_add_seq
  import rip_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RIP_ADD_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_w(NIB);

  rip_add_seq_state_t state, next_state;

  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    nib_base;
  logic             last_nib;
  logic             accept;

  logic [NIB_W-1:0] add_a, add_b, add_sum;
  logic             add_cout;

  // Bit offset of the current nibble (idx * 4).
  assign nib_base = {idx, 2'b00};
  assign last_nib = (idx == IW'(NIB - 1));
  assign accept   = in_valid && in_ready;

  assign add_a = a_reg[nib_base +: NIB_W];
  assign add_b = b_reg[nib_base +: NIB_W];

  rip_add u_add (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // The carry register doubles as cout: it holds the final carry in DONE and
  // nothing touches it again until the next accept.
  assign sum  = sum_reg;
  assign cout = carry;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then fold one nibble per RUN cycle
  // into the result while carrying between nibbles. DONE leaves everything
  // untouched so the result stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else begin
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        carry   <= cin;
        idx     <= '0;
        sum_reg <= '0;
      end else if (state == RUN) begin
        sum_reg[nib_base +: NIB_W] <= add_sum;
        carry                      <= add_cout;
        idx                        <= last_nib ? '0 : idx + IW'(1);
      end
    end
  end

`ifdef RIP_ADD_SEQ_OVF_EN
  // Overflow is judged when the top nibble is written, using that nibble's
  // fresh sum bit as the result MSB; it is dropped again on leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_nib) begin
      ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
             (add_sum[NIB_W-1] != a_reg[WIDTH-1]);
    end else if (state == DONE && out_ready) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rip_add_seq.sv
// tb_rip_add_seq
// Directed bench for rip_add_seq at WIDTH=16. Expected results come from a
// behavioural model (plain integer addition) pushed to a scoreboard at accept
// time and popped when the DUT presents out_valid.

module tb_rip_add_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef RIP_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rip_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef RIP_ADD_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Absolute safety net in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: exact wide addition plus signed-overflow rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Waits for in_ready, presents operands for one accept edge, records the
  // expected result and then scrambles the inputs to show they are not reused.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkValue("in_ready_wait", in_ready, 1);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    tick();
    sb.push_back(model(x, y, c));
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
  endtask

  // Waits for out_valid, compares against the scoreboard head, releases the
  // result and confirms the sequencer is ready again one cycle later.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkValue({tag, "_out_valid"}, out_valid, 1);
    e = sb.pop_front();
    checkValue({tag, "_sum"}, sum, e.sum);
    checkValue({tag, "_cout"}, cout, e.cout);
`ifdef RIP_ADD_SEQ_OVF_EN
    checkValue({tag, "_ovf"}, ovf, e.ovf);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkValue({tag, "_in_ready_after"}, in_ready, 1);
    checkValue({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    bit seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkValue("rst_in_ready", in_ready, 1);
    checkValue("rst_out_valid", out_valid, 0);
    checkValue("rst_busy", busy, 0);
    checkValue("rst_sum", sum, 0);
    checkValue("rst_cout", cout, 0);
`ifdef RIP_ADD_SEQ_OVF_EN
    checkValue("rst_ovf", ovf, 0);
`endif

    $display("[TB] zero add with latency check");
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkValue($sformatf("lat_busy_%0d", k), busy, 1);
      checkValue($sformatf("lat_out_valid_%0d", k), out_valid, 0);
      checkValue($sformatf("lat_in_ready_%0d", k), in_ready, 0);
      tick();
    end
    checkValue("lat_out_valid_rise", out_valid, 1);
    checkValue("lat_busy_fall", busy, 0);
    checkOutput("zero");

    $display("[TB] carry across nibbles");
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    checkOutput("carry2");

    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    checkOutput("allones_cin");

    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("wrap");

    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput("pos_ovf");

    applyStimulus(16'h0F0F, 16'h00F1, 1'b1);
    checkOutput("mixed");

    $display("[TB] backpressure");
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    begin
      int waited = 0;
      while (out_valid !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
    end
    a        = 16'hAAAA;
    b        = 16'h1111;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkValue($sformatf("bp_out_valid_%0d", k), out_valid, 1);
      checkValue($sformatf("bp_sum_%0d", k), sum, 16'h5555);
      checkValue($sformatf("bp_cout_%0d", k), cout, 0);
      checkValue($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      tick();
    end
    checkOutput("bp");
    tick();
    sb.push_back(model(16'hAAAA, 16'h1111, 1'b1));
    in_valid = 1'b0;
    checkValue("bp_new_busy", busy, 1);
    checkValue("bp_new_in_ready", in_ready, 0);
    checkOutput("bp_new");

    $display("[TB] reset mid-run");
    applyStimulus(16'h1111, 16'h2222, 1'b1);
    void'(sb.pop_back());
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkValue("abort_sum", sum, 0);
    checkValue("abort_cout", cout, 0);
    checkValue("abort_in_ready", in_ready, 1);
    checkValue("abort_busy", busy, 0);
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) seen_valid = 1'b1;
      tick();
    end
    checkValue("abort_no_out_valid", seen_valid, 0);

    applyStimulus(16'h8000, 16'h8000, 1'b0);
    checkOutput("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
